// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, handshaked ALU with an iterative multiplier
//
// Purpose:
//   Takes an opcode and two WIDTH-bit operands over a valid/ready input
//   handshake. It returns the result through a one-entry output register
//   guarded by a valid/ready output handshake.
//   Single-cycle ops (AND, OR, ADD, SUB, XOR, SLT, NOR) have a latency of
//   1 and can stream at one per clock. MUL is a shift-add loop that
//   processes one bit of B per cycle, giving a latency of WIDTH+1. The
//   input side stays closed while the loop runs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation this cycle
//   A, B       WIDTH-bit operands
//   Ctrl       CTRL_W-bit opcode (0..7 legal, everything above is illegal)
//   out_valid  Y/err(/flags) valid, held until consumed
//   out_ready  consumer accepts Y
//   Y          registered result
//   err        registered illegal-opcode indication
//   flags      {Z,N,C,V} registered with Y (ALU_SEQ_FLAGS_EN only)
//
// Configuration macro:
//   ALU_SEQ_FLAGS_EN  when defined, the flags port and its logic exist.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [CTRL_W-1:0] Ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  Y,
    output logic              err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic [3:0]        flags
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(7);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mul_a;
    logic [WIDTH-1:0]  mul_b;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  mul_next;

    logic [WIDTH-1:0]  add_y;
    logic [WIDTH-1:0]  sub_y;
    logic              slt;
    logic [WIDTH-1:0]  alu_y;
    logic              alu_err;
    logic              accept;

    // Ready also drops while rst_n is low, so nothing is taken during reset.
    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Partial product for this step: add the shifted A when the current B bit is set.
    assign mul_next = acc + (mul_b[0] ? mul_a : '0);

    assign slt = $signed(A) < $signed(B);

`ifdef ALU_SEQ_FLAGS_EN
    // Sums are formed one bit wider so the carry / borrow falls out directly.
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           alu_c;
    logic           alu_v;

    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};
    assign add_y    = sum_ext[WIDTH-1:0];
    assign sub_y    = diff_ext[WIDTH-1:0];

    // C is carry-out for ADD and no-borrow for SUB.
    // V is set when the sign of the result disagrees with the operand signs.
    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (Ctrl)
            OP_ADD: begin
                alu_c = sum_ext[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_y[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c = ~diff_ext[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_y[WIDTH-1] != A[WIDTH-1]);
            end
            default: begin
                alu_c = 1'b0;
                alu_v = 1'b0;
            end
        endcase
    end
`else
    assign add_y = A + B;
    assign sub_y = A - B;
`endif

    // Single-cycle result selection.
    // Illegal codes give Y=0 with err set. MUL is handled by the loop,
    // so its entry here is never registered.
    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (Ctrl)
            OP_AND:  alu_y = A & B;
            OP_OR:   alu_y = A | B;
            OP_ADD:  alu_y = add_y;
            OP_SUB:  alu_y = sub_y;
            OP_XOR:  alu_y = A ^ B;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR:  alu_y = ~(A | B);
            OP_MUL:  alu_y = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM and output register.
    // A pop clears out_valid first. A result landing in the same cycle then
    // sets it again, so back-to-back ops keep out_valid high. In MUL the
    // operands were latched at accept, so the live A/B/Ctrl inputs are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Y         <= '0;
            err       <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            count     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            flags     <= 4'b0000;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (Ctrl == OP_MUL) begin
                            state <= MUL;
                            mul_a <= A;
                            mul_b <= B;
                            acc   <= '0;
                            count <= '0;
                        end else begin
                            Y         <= alu_y;
                            err       <= alu_err;
                            out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                            flags     <= {alu_y == '0, alu_y[WIDTH-1], alu_c, alu_v};
`endif
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state     <= IDLE;
                        Y         <= mul_next;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                        flags     <= {mul_next == '0, mul_next[WIDTH-1], 1'b0, 1'b0};
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32, CTRL_W=4)
//
// Runs a reset check and a table of single-cycle vectors. Hand-written
// sequences then cover multiply latency, output stall, and reset during a
// multiply. A randomized phase is scored against a transaction-level
// reference model.
// Flags are checked only when ALU_SEQ_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic [CTRL_W-1:0] ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  y;
    logic              err;
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]        flags;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        err;
        logic [3:0]  flags;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        err;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[15];
    res_t exp_q[$];
    int   busy = 0;

    alu_seq #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (y),
        .err       (err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode meaning.
    function automatic res_t refModel(input logic [3:0] op, input logic [31:0] x, input logic [31:0] z);
        res_t r;
        longint sx, sz, s;
        longint unsigned ux, uz, u;
        logic c, v;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ux = x;
        uz = z;
        c = 1'b0;
        v = 1'b0;
        r.y = '0;
        r.err = 1'b0;
        case (op)
            4'd0: r.y = x & z;
            4'd1: r.y = x | z;
            4'd2: begin
                u = ux + uz;
                r.y = u[31:0];
                c = (u >= 64'h1_0000_0000);
                s = sx + sz;
                v = (s > SMAX) || (s < SMIN);
            end
            4'd3: begin
                r.y = x - z;
                c = (x >= z);
                s = sx - sz;
                v = (s > SMAX) || (s < SMIN);
            end
            4'd4: r.y = x ^ z;
            4'd5: r.y = (sx < sz) ? 32'd1 : 32'd0;
            4'd6: r.y = ~(x | z);
            4'd7: begin
                u = ux * uz;
                r.y = u[31:0];
            end
            default: r.err = 1'b1;
        endcase
        r.flags = {r.y == 32'd0, r.y[31], c, v};
        return r;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [3:0] op, input logic [31:0] xa,
                                 input logic [31:0] xb, input logic ordy);
        in_valid  = iv;
        ctrl      = op;
        a         = xa;
        b         = xb;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle: predict ready/valid from the model, score pops, record accepts.
    task automatic runCycle(input logic iv, input logic [3:0] op, input logic [31:0] xa,
                            input logic [31:0] xb, input logic ordy);
        logic exp_ov;
        logic exp_rdy;
        res_t r;
        applyStimulus(iv, op, xa, xb, ordy);
        #1;
        exp_ov  = (exp_q.size() > 0) && (busy == 0);
        exp_rdy = (busy == 0) && (!exp_ov || ordy);
        checkOutput("rand out_valid", out_valid, exp_ov);
        checkOutput("rand in_ready", in_ready, exp_rdy);
        if (busy > 0) busy--;
        if (exp_ov && ordy) begin
            r = exp_q.pop_front();
            checkOutput("rand Y", y, r.y);
            checkOutput("rand err", err, r.err);
`ifdef ALU_SEQ_FLAGS_EN
            checkOutput("rand flags", flags, r.flags);
`endif
        end
        if (iv && exp_rdy) begin
            exp_q.push_back(refModel(op, xa, xb));
            if (op == 4'd7) busy = WIDTH;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Guard against a hung design.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic seen_valid;
        logic [3:0] rop;

        vecs[0]  = '{4'd0, 32'd2, 32'd1, 32'h0000_0000, 1'b0, 4'b1000};
        vecs[1]  = '{4'd1, 32'd2, 32'd1, 32'h0000_0003, 1'b0, 4'b0000};
        vecs[2]  = '{4'd2, 32'd2, 32'd1, 32'h0000_0003, 1'b0, 4'b0000};
        vecs[3]  = '{4'd3, 32'd2, 32'd1, 32'h0000_0001, 1'b0, 4'b0010};
        vecs[4]  = '{4'd4, 32'd2, 32'd1, 32'h0000_0003, 1'b0, 4'b0000};
        vecs[5]  = '{4'd5, 32'd2, 32'd1, 32'h0000_0000, 1'b0, 4'b1000};
        vecs[6]  = '{4'd6, 32'd2, 32'd1, 32'hFFFF_FFFC, 1'b0, 4'b0100};
        vecs[7]  = '{4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 4'b1010};
        vecs[8]  = '{4'd3, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 4'b0011};
        vecs[9]  = '{4'd5, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b0, 4'b0000};
        vecs[10] = '{4'd9, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1, 4'b1000};
        vecs[11] = '{4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 4'b0101};
        vecs[12] = '{4'd3, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'b0100};
        vecs[13] = '{4'd15, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 4'b1000};
        vecs[14] = '{4'd0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 1'b0, 4'b0000};

        // Reset held for two cycles with a valid request present.
        applyStimulus(1'b1, 4'd2, 32'd5, 32'd5, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset in_ready", in_ready, 1'b0);
        tick();
        tick();
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset Y", y, 32'd0);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset in_ready held", in_ready, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("reset flags", flags, 4'b0000);
`endif
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checkOutput("post-reset in_ready", in_ready, 1'b1);

        // Table vectors streamed back-to-back, one result per clock.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
            checkOutput($sformatf("vec%0d Y", i), y, vecs[i].y);
            checkOutput($sformatf("vec%0d err", i), err, vecs[i].err);
            checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
            checkOutput($sformatf("vec%0d flags", i), flags, vecs[i].flags);
`endif
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("table drain out_valid", out_valid, 1'b0);

        // MUL 7*6 with junk requests offered while busy; output held back on arrival.
        applyStimulus(1'b1, 4'd7, 32'd7, 32'd6, 1'b1);
        tick();
        applyStimulus(1'b1, 4'd2, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            checkOutput("mul busy in_ready", in_ready, 1'b0);
            tick();
            lat++;
        end
        checkOutput("mul latency", lat, 33);
        checkOutput("mul Y", y, 32'd42);
        checkOutput("mul err", err, 1'b0);
        checkOutput("mul stalled in_ready", in_ready, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("mul flags", flags, 4'b0000);
`endif
        tick();
        checkOutput("mul held Y", y, 32'd42);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("mul pop out_valid", out_valid, 1'b0);

        // Output stall: ADD result held for 5 cycles, then pop + accept together.
        applyStimulus(1'b1, 4'd2, 32'd10, 32'd20, 1'b1);
        tick();
        checkOutput("stall first valid", out_valid, 1'b1);
        checkOutput("stall first Y", y, 32'd30);
        applyStimulus(1'b1, 4'd1, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("stall%0d in_ready", i), in_ready, 1'b0);
            tick();
            checkOutput($sformatf("stall%0d Y", i), y, 32'd30);
            checkOutput($sformatf("stall%0d out_valid", i), out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("stall release in_ready", in_ready, 1'b1);
        tick();
        checkOutput("stall next valid", out_valid, 1'b1);
        checkOutput("stall next Y", y, 32'h0000_00FF);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checkOutput("stall drain out_valid", out_valid, 1'b0);

        // Reset in the middle of a multiply: no result may appear afterwards.
        applyStimulus(1'b1, 4'd7, 32'd3, 32'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("abort in_ready", in_ready, 1'b1);
        checkOutput("abort out_valid", out_valid, 1'b0);
        seen_valid = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("abort no result", seen_valid, 1'b0);
        checkOutput("abort idle", in_ready, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'd7 && $urandom_range(0, 3) != 0) rop = 4'd2;
            runCycle($urandom_range(0, 3) != 0, rop, pickOperand(), pickOperand(),
                     $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) begin
            runCycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        end
        checkOutput("rand drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
